register_serializer: RTL and testbench
======================================

Name: register_serializer

Overview:
Parallel-in, serial-out transmitter that drains a word out of the register datapath.
- Accepts a WIDTH-bit word on a LOAD/READY handshake and shifts it out one bit per enabled clock on SOUT.
- Frame markers: SVALID, LAST and a DONE pulse.
- Sits downstream of the 8-bit register block; it is the reading end of that register's parallel interface.

Parameters:
WIDTH, 8, word width in bits (>= 2)
MSB_FIRST, 1, 1 = shift DATA[WIDTH-1] first; 0 = shift DATA[0] first

Ports:
CLK  input  1  rising-edge clock, the single clock
RST  input  1  reset, asynchronous and active-low; clears all state
ENA  input  1  shift enable; when low in SHIFT, all state holds
LOAD  input  1  word-valid from the producer
DATA  input  WIDTH  parallel word, sampled only when LOAD and READY are both high at a clock edge
READY  output  1  accept indication (combinational from state/ENA)
SOUT  output  WIDTH=1 bit  current serial bit
SVALID  output  1  SOUT carries a frame bit
LAST  output  1  SOUT is the final bit of the frame
DONE  output  1  one-cycle pulse after a frame's last bit is consumed

Behaviour:
- Reset (RST low, asynchronous, any time including mid-frame):
  - State goes to IDLE; shift register and bit counter clear.
  - SOUT=0, SVALID=0, LAST=0, DONE=0, READY=1.
  - The current frame is discarded; LOAD is ignored while RST is low.
- FSM states: IDLE, SHIFT.
- IDLE:
  - READY=1, SVALID=0, SOUT=0.
  - Edge with LOAD=1: shift register <= DATA, counter <= WIDTH-1, go to SHIFT.
  - ENA is don't-care in IDLE.
- SHIFT:
  - SVALID=1.
  - SOUT = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - LAST = (counter==0).
- SHIFT, edge with ENA=1 and counter!=0: shift by one toward the output end (zero fill); counter decrements.
- SHIFT, edge with ENA=1 and counter==0 (last bit consumed):
  - DONE=1 for exactly the next cycle.
  - If LOAD=1: reload DATA, counter <= WIDTH-1, stay in SHIFT (back-to-back, no bubble).
  - Else go to IDLE.
- SHIFT, edge with ENA=0: hold everything; SOUT/SVALID/LAST stable; no DONE.
- READY = (state==IDLE) | (state==SHIFT & LAST & ENA). LOAD while READY=0 is ignored; the in-flight word is never corrupted.
- Latency:
  - First bit is on SOUT the cycle after acceptance.
  - With ENA held high, a frame occupies exactly WIDTH cycles of SVALID.
  - DONE is registered, asserting the cycle after the LAST cycle.
- DONE pulses once per completed frame, including back-to-back frames (in which case it overlaps bit 0 of the next frame).
- Counter width is clog2(WIDTH); no wrap past 0 (it is reloaded or left in IDLE).

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default word width constant REG_WIDTH=8.
- Top module holds the FSM, counter, READY/LAST/DONE logic.
- One sub-module is natural: piso_shift_reg, a WIDTH-bit load/shift/hold datapath with asynchronous active-low clear and MSB_FIRST select. Its control inputs are load and shift; its output is the serial bit.

Test Plan:
- Reset, LOAD 8'hA5, ENA=1, MSB_FIRST=1 -> SOUT 1,0,1,0,0,1,0,1 on 8 consecutive SVALID cycles; LAST on cycle 8; DONE high on cycle 9; READY back to 1.
- MSB_FIRST=0, LOAD 8'h01, ENA=1 -> SOUT 1 then seven 0s; LAST on the 8th bit.
- LOAD 8'hC3 with ENA alternating 1,0 each cycle -> each bit held 2 cycles, 16 SVALID cycles, sequence 1,1,0,0,0,0,1,1, a single DONE.
- LOAD 8'hF0, then LOAD=1 with 8'h0F during the LAST&ENA cycle -> 16 contiguous SVALID cycles, SOUT 11110000 00001111; DONE on the cycle after bit 8 and after bit 16.
- LOAD 8'h81, assert LOAD with 8'hFF at bit 3 (READY=0) -> ignored; SOUT stays 1,0,0,0,0,0,0,1.
- LOAD 8'hAA, drop RST asynchronously mid-clock after 3 bits -> SVALID/SOUT/LAST/DONE go 0 and READY 1 immediately; after release, LOAD 8'h55 serializes cleanly from bit 7.

Source files
------------

// File: rtl/register_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_serializer_pkg
// Brief    : Shared state encoding and default word width for the serializer.
// Revision : 1.0
// ============================================================================
package register_serializer_pkg;

    localparam int REG_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : register_serializer_pkg
`default_nettype wire

// File: rtl/register_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : register_serializer_if
// Brief    : Load handshake plus serial frame outputs of the serializer.
// Revision : 1.0
// ============================================================================
interface register_serializer_if
    import register_serializer_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
);
    logic             ena;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             sout;
    logic             svalid;
    logic             last;
    logic             done;

    modport master (
        output ena, load, data,
        input  ready, sout, svalid, last, done
    );

    modport slave (
        input  ena, load, data,
        output ready, sout, svalid, last, done
    );
endinterface : register_serializer_if
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_reg
// Brief    : Load/shift/hold parallel-in serial-out register, zero fill.
// Revision : 1.0
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic             i_shift,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_sout
);
    logic [WIDTH-1:0] r_sreg;

    generate
        if (MSB_FIRST) begin : g_msb_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_sreg <= '0;
                else if (i_load)  r_sreg <= i_data;
                else if (i_shift) r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
            end
            assign o_sout = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_sreg <= '0;
                else if (i_load)  r_sreg <= i_data;
                else if (i_shift) r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
            end
            assign o_sout = r_sreg[0];
        end
    endgenerate

endmodule : piso_shift_reg
`default_nettype wire

// File: rtl/register_serializer.sv
`default_nettype none
// ============================================================================
// Module   : register_serializer
// Brief    : Word-to-bitstream transmitter with LAST/DONE framing markers.
// Revision : 1.0
// ============================================================================
module register_serializer
    import register_serializer_pkg::*;
#(
    parameter int WIDTH     = REG_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    register_serializer_if.slave bus
);
    localparam int                 c_cnt_w   = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;
    logic               w_in_shift;
    logic               w_last;
    logic               w_ready;
    logic               w_accept;
    logic               w_shift;
    logic               w_frame_end;
    logic               w_bit;

    assign w_in_shift  = (r_state == ST_SHIFT);
    assign w_last      = w_in_shift && (r_cnt == '0);
    assign w_ready     = (r_state == ST_IDLE) || (w_last && bus.ena);
    assign w_accept    = bus.load && w_ready;
    assign w_frame_end = w_last && bus.ena;
    // Shifting on the final bit too drains the register to zero before IDLE.
    assign w_shift     = w_in_shift && bus.ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.load) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_frame_end && !bus.load) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_accept)
                r_cnt <= c_cnt_max;
            else if (w_shift && (r_cnt != '0))
                r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (bus.data),
        .o_sout  (w_bit)
    );

    assign bus.ready  = w_ready;
    assign bus.svalid = w_in_shift;
    assign bus.sout   = w_bit && w_in_shift;
    assign bus.last   = w_last;
    assign bus.done   = r_done;

endmodule : register_serializer
`default_nettype wire

// File: tb/tb_register_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_serializer
// Brief    : Scoreboard bench for MSB-first and LSB-first serializer copies.
// Revision : 1.0
// ============================================================================
module tb_register_serializer;
    import register_serializer_pkg::*;

    localparam int W = REG_WIDTH;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena   = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] data  = '0;

    always #5 clk = ~clk;

    register_serializer_if #(.WIDTH(W)) bus_m ();
    register_serializer_if #(.WIDTH(W)) bus_l ();

    assign bus_m.ena  = ena;
    assign bus_m.load = load;
    assign bus_m.data = data;
    assign bus_l.ena  = ena;
    assign bus_l.load = load;
    assign bus_l.data = data;

    register_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m.slave)
    );

    register_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l.slave)
    );

    // Reference model: bits left in the current frame, plus the bit queues
    exp_t q_m[$];
    exp_t q_l[$];
    int   rem      = 0;
    bit   exp_done = 1'b0;
    bit   run      = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b = d[i]; e.last = (i == 0);
            q_m.push_back(e);
        end
        for (int i = 0; i < W; i++) begin
            e.b = d[i]; e.last = (i == W - 1);
            q_l.push_back(e);
        end
    endtask

    // Apply inputs for one cycle, then advance the model across the edge.
    task automatic cycle(input logic l, input logic [W-1:0] d, input logic e);
        bit rdy;
        load = l; data = d; ena = e;
        @(posedge clk);
        if (rst_n) begin
            rdy      = (rem == 0) || (rem == 1 && e);
            exp_done = (rem == 1 && e);
            if (rem > 0 && e) rem--;
            if (l && rdy) begin
                rem = W;
                push_word(d);
            end
        end
        #1;
    endtask

    task automatic check_lane(input int k, input logic rd, input logic sv,
                              input logic so, input logic la, input logic dn);
        exp_t f;
        check($sformatf("ready%0d", k),  rd, (rem == 0) || (rem == 1 && ena));
        check($sformatf("svalid%0d", k), sv, rem > 0);
        check($sformatf("done%0d", k),   dn, exp_done);
        if (sv) begin
            if ((k == 0 ? q_m.size() : q_l.size()) == 0) begin
                check($sformatf("underflow%0d", k), sv, 1'b0);
            end else begin
                f = (k == 0) ? q_m[0] : q_l[0];
                check($sformatf("sout%0d", k), so, f.b);
                check($sformatf("last%0d", k), la, f.last);
                if (ena) begin
                    if (k == 0) void'(q_m.pop_front());
                    else        void'(q_l.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (run && rst_n) begin
            check_lane(0, bus_m.ready, bus_m.svalid, bus_m.sout, bus_m.last, bus_m.done);
            check_lane(1, bus_l.ready, bus_l.svalid, bus_l.sout, bus_l.last, bus_l.done);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_svalid_m"}, bus_m.svalid, 1'b0);
        check({tag, "_sout_m"},   bus_m.sout,   1'b0);
        check({tag, "_last_m"},   bus_m.last,   1'b0);
        check({tag, "_done_m"},   bus_m.done,   1'b0);
        check({tag, "_ready_m"},  bus_m.ready,  1'b1);
        check({tag, "_svalid_l"}, bus_l.svalid, 1'b0);
        check({tag, "_ready_l"},  bus_l.ready,  1'b1);
    endtask

    initial begin
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run   = 1'b1;

        // A5 MSB/LSB, ENA held high
        cycle(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        // C3 with ENA alternating
        cycle(1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 18; i++) cycle(1'b0, '0, (i % 2) == 1);
        for (int i = 0; i < 2; i++)  cycle(1'b0, '0, 1'b1);
        // F0 then 0F back to back during the LAST cycle
        cycle(1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < 7; i++)  cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'h0F, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        // 81 with an ignored FF mid-frame
        cycle(1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 2; i++)  cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 7; i++)  cycle(1'b0, '0, 1'b1);

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 4 * W; i++) cycle(1'b0, '0, 1'b1);

        // Asynchronous reset in the middle of an AA frame
        cycle(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        rem = 0; exp_done = 1'b0;
        q_m.delete(); q_l.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b1);
        rst_n = 1'b1;
        cycle(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);

        check("drain_m", q_m.size() == 0, 1'b1);
        check("drain_l", q_l.size() == 0, 1'b1);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_register_serializer
`default_nettype wire
